// File: rtl/ex_muldiv_unit_if.sv
// rtl/ex_muldiv_unit_if.sv - operand/result bundle between ID/EX and the multiply/divide unit
interface ex_muldiv_unit_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] operandA;
   logic [WIDTH-1:0] operandB;
   logic             mthi;
   logic             mtlo;
   logic [WIDTH-1:0] hiOut;
   logic [WIDTH-1:0] loOut;
   logic             busyOut;
   logic             stallOut;

   modport master (
      output start, op, operandA, operandB, mthi, mtlo,
      input  hiOut, loOut, busyOut, stallOut
   );

   modport slave (
      input  start, op, operandA, operandB, mthi, mtlo,
      output hiOut, loOut, busyOut, stallOut
   );
endinterface

// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - multi-cycle MULT/MULTU/DIV/DIVU unit owning HI/LO
// State advances on the falling clock edge, in step with the pipeline registers.
module ex_muldiv_unit #(
   parameter int WIDTH = 32,
   parameter int ITER  = 32
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            debugEnable,
   input  logic            debugReset,
   ex_muldiv_unit_if.slave bus
);
   localparam int CW = $clog2(ITER);
   localparam logic [CW-1:0] C_LAST = CW'(ITER - 1);
   localparam logic [CW-1:0] C_ONE  = CW'(1);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FINISH} state_t;

   state_t             r_state;
   logic [CW-1:0]      r_count;
   logic [2*WIDTH-1:0] r_acc;
   logic [WIDTH-1:0]   r_opnd;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic               r_busy;
   logic               r_div;
   logic               r_dz;
   logic               r_sign_a;
   logic               r_sign_b;

   logic               w_sign_a;
   logic               w_sign_b;
   logic [WIDTH-1:0]   w_abs_a;
   logic [WIDTH-1:0]   w_abs_b;
   logic [WIDTH:0]     w_mul_sum;
   logic [WIDTH:0]     w_trial;
   logic [WIDTH:0]     w_diff;
   logic [2*WIDTH-1:0] w_prod;
   logic [WIDTH-1:0]   w_quo;
   logic [WIDTH-1:0]   w_rem;

   assign w_sign_a = ~bus.op[0] & bus.operandA[WIDTH-1];
   assign w_sign_b = ~bus.op[0] & bus.operandB[WIDTH-1];
   assign w_abs_a  = w_sign_a ? -bus.operandA : bus.operandA;
   assign w_abs_b  = w_sign_b ? -bus.operandB : bus.operandB;

   // Multiply: r_acc = {partial product, remaining multiplier bits}, r_opnd = multiplicand.
   assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);

   // Divide: r_acc = {partial remainder, dividend/quotient}, r_opnd = divisor.
   assign w_trial = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
   assign w_diff  = w_trial - {1'b0, r_opnd};

   assign w_prod = (r_sign_a ^ r_sign_b) ? -r_acc : r_acc;
   assign w_quo  = (r_sign_a ^ r_sign_b) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
   assign w_rem  = r_sign_a ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

   assign bus.hiOut    = r_hi;
   assign bus.loOut    = r_lo;
   assign bus.busyOut  = r_busy;
   assign bus.stallOut = r_busy | (bus.start & (r_state == S_IDLE));

   always_ff @(negedge clock or posedge reset) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_count  <= '0;
         r_acc    <= '0;
         r_opnd   <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_busy   <= 1'b0;
         r_div    <= 1'b0;
         r_dz     <= 1'b0;
         r_sign_a <= 1'b0;
         r_sign_b <= 1'b0;
      end else if (debugReset) begin
         r_state  <= S_IDLE;
         r_count  <= '0;
         r_acc    <= '0;
         r_opnd   <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_busy   <= 1'b0;
         r_div    <= 1'b0;
         r_dz     <= 1'b0;
         r_sign_a <= 1'b0;
         r_sign_b <= 1'b0;
      end else if (debugEnable) begin
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_div    <= bus.op[1];
                  r_sign_a <= w_sign_a;
                  r_sign_b <= w_sign_b;
                  r_count  <= '0;
                  r_busy   <= 1'b1;
                  if (bus.op[1] && (bus.operandB == '0)) begin
                     // Divide by zero skips iteration; the result is parked in r_acc.
                     r_dz    <= 1'b1;
                     r_acc   <= {bus.operandA, {WIDTH{1'b1}}};
                     r_state <= S_FINISH;
                  end else begin
                     r_dz    <= 1'b0;
                     r_acc   <= {{WIDTH{1'b0}}, (bus.op[1] ? w_abs_a : w_abs_b)};
                     r_opnd  <= bus.op[1] ? w_abs_b : w_abs_a;
                     r_state <= S_BUSY;
                  end
               end else begin
                  if (bus.mthi) r_hi <= bus.operandA;
                  if (bus.mtlo) r_lo <= bus.operandA;
               end
            end
            S_BUSY: begin
               if (r_div)
                  r_acc <= {(w_diff[WIDTH] ? w_trial[WIDTH-1:0] : w_diff[WIDTH-1:0]),
                            r_acc[WIDTH-2:0], ~w_diff[WIDTH]};
               else
                  r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
               if (r_count == C_LAST)
                  r_state <= S_FINISH;
               else
                  r_count <= r_count + C_ONE;
            end
            S_FINISH: begin
               if (r_dz) begin
                  r_hi <= r_acc[2*WIDTH-1:WIDTH];
                  r_lo <= r_acc[WIDTH-1:0];
               end else if (r_div) begin
                  r_hi <= w_rem;
                  r_lo <= w_quo;
               end else begin
                  r_hi <= w_prod[2*WIDTH-1:WIDTH];
                  r_lo <= w_prod[WIDTH-1:0];
               end
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb/tb_ex_muldiv_unit.sv - directed self-checking bench for ex_muldiv_unit
module tb_ex_muldiv_unit;
   logic clock = 1'b0;
   logic reset;
   logic debugEnable;
   logic debugReset;
   int   n_tests = 0;
   int   n_fail  = 0;

   ex_muldiv_unit_if #(.WIDTH(32)) bus ();

   ex_muldiv_unit #(.WIDTH(32), .ITER(32)) dut (
      .clock       (clock),
      .reset       (reset),
      .debugEnable (debugEnable),
      .debugReset  (debugReset),
      .bus         (bus)
   );

   always #5 clock = ~clock;

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic edges(input int n);
      repeat (n) begin
         @(negedge clock);
         #1;
      end
   endtask

   // Presents start for one falling edge (edge 1) and then drops it.
   task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      bus.op       = op;
      bus.operandA = a;
      bus.operandB = b;
      bus.start    = 1'b1;
      edges(1);
      bus.start    = 1'b0;
   endtask

   initial begin
      reset        = 1'b1;
      debugReset   = 1'b0;
      debugEnable  = 1'b1;
      bus.start    = 1'b0;
      bus.op       = 2'b00;
      bus.operandA = '0;
      bus.operandB = '0;
      bus.mthi     = 1'b0;
      bus.mtlo     = 1'b0;
      edges(2);
      chk32("reset_hi", bus.hiOut, 32'h0);
      chk32("reset_lo", bus.loOut, 32'h0);
      chk1("reset_busy", bus.busyOut, 1'b0);
      chk1("reset_stall", bus.stallOut, 1'b0);
      reset = 1'b0;

      bus.op = 2'b01; bus.operandA = 32'hFFFF_FFFF; bus.operandB = 32'hFFFF_FFFF;
      bus.start = 1'b1;
      #1;
      chk1("stall_on_start", bus.stallOut, 1'b1);
      edges(1);
      bus.start = 1'b0;
      chk1("multu_busy_e1", bus.busyOut, 1'b1);
      chk1("multu_stall_e1", bus.stallOut, 1'b1);
      edges(32);
      chk1("multu_busy_e33", bus.busyOut, 1'b1);
      chk32("multu_lo_e33", bus.loOut, 32'h0);
      edges(1);
      chk1("multu_busy_e34", bus.busyOut, 1'b0);
      chk1("multu_stall_e34", bus.stallOut, 1'b0);
      chk32("multu_hi", bus.hiOut, 32'hFFFF_FFFE);
      chk32("multu_lo", bus.loOut, 32'h0000_0001);

      launch(2'b00, 32'hFFFF_FFFD, 32'h0000_0007);
      edges(33);
      chk32("mult_hi", bus.hiOut, 32'hFFFF_FFFF);
      chk32("mult_lo", bus.loOut, 32'hFFFF_FFEB);

      launch(2'b10, 32'hFFFF_FFF9, 32'h0000_0002);
      edges(33);
      chk32("div_lo", bus.loOut, 32'hFFFF_FFFD);
      chk32("div_hi", bus.hiOut, 32'hFFFF_FFFF);

      launch(2'b11, 32'd100, 32'd7);
      edges(33);
      chk32("divu_lo", bus.loOut, 32'd14);
      chk32("divu_hi", bus.hiOut, 32'd2);

      launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
      edges(33);
      chk32("divmin_lo", bus.loOut, 32'h8000_0000);
      chk32("divmin_hi", bus.hiOut, 32'h0);

      launch(2'b10, 32'h1234_5678, 32'h0);
      chk1("dz_busy_e1", bus.busyOut, 1'b1);
      edges(1);
      chk1("dz_busy_e2", bus.busyOut, 1'b0);
      chk32("dz_hi", bus.hiOut, 32'h1234_5678);
      chk32("dz_lo", bus.loOut, 32'hFFFF_FFFF);

      bus.mthi = 1'b1;
      launch(2'b01, 32'd3, 32'd5);
      bus.mthi = 1'b0;
      chk32("start_beats_mthi", bus.hiOut, 32'h1234_5678);
      edges(4);
      bus.mtlo = 1'b1; bus.operandA = 32'hA5A5_A5A5;
      edges(1);
      bus.mtlo = 1'b0;
      chk32("mtlo_busy_ignored", bus.loOut, 32'hFFFF_FFFF);
      edges(28);
      chk32("mul3x5_hi", bus.hiOut, 32'h0);
      chk32("mul3x5_lo", bus.loOut, 32'd15);
      bus.mtlo = 1'b1; bus.operandA = 32'hA5A5_A5A5;
      edges(1);
      bus.mtlo = 1'b0;
      chk32("mtlo_idle", bus.loOut, 32'hA5A5_A5A5);
      chk32("mtlo_idle_hi", bus.hiOut, 32'h0);

      launch(2'b01, 32'd1000, 32'd1000);
      edges(9);
      debugEnable = 1'b0;
      edges(5);
      chk1("frozen_busy", bus.busyOut, 1'b1);
      chk32("frozen_lo", bus.loOut, 32'hA5A5_A5A5);
      debugEnable = 1'b1;
      edges(23);
      chk1("dbg_busy_e38", bus.busyOut, 1'b1);
      edges(1);
      chk1("dbg_busy_e39", bus.busyOut, 1'b0);
      chk32("dbg_lo", bus.loOut, 32'h000F_4240);
      chk32("dbg_hi", bus.hiOut, 32'h0);

      launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      edges(8);
      #2;
      reset = 1'b1;
      #1;
      chk1("async_rst_busy", bus.busyOut, 1'b0);
      chk32("async_rst_hi", bus.hiOut, 32'h0);
      chk32("async_rst_lo", bus.loOut, 32'h0);
      reset = 1'b0;
      edges(30);
      chk1("after_rst_busy", bus.busyOut, 1'b0);
      chk32("after_rst_lo", bus.loOut, 32'h0);

      bus.mthi = 1'b1; bus.operandA = 32'h0000_0077;
      edges(1);
      bus.mthi = 1'b0;
      chk32("mthi_idle", bus.hiOut, 32'h0000_0077);
      debugReset = 1'b1;
      edges(1);
      debugReset = 1'b0;
      chk32("dbgrst_hi", bus.hiOut, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
